shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle controller that performs logical-right, logical-left or arithmetic-right shifts one bit per clock.
- Provides a start/busy/done handshake, zero and carry flags, and caps the iteration count at N.
- Sits beside the combinational ALU shift units. Used wherever a shift must be sequenced over several cycles, e.g. the FSM-driven datapath, instead of being resolved in a single combinational path.

Parameters:
N, 4, operand/result width in bits (N >= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  00 = LSR, 01 = LSL, 10 = ASR, 11 = reserved (pass-through)
a  input  N  operand to shift, captured when start is accepted
b  input  N  shift amount, unsigned, captured when start is accepted
busy  output  1  high in SHIFT and DONE states
done  output  1  one-cycle pulse: result/flags valid for the completed operation
result  output  N  shifted value; held until the next completion
flagZ  output  1  1 when result == 0
flagC  output  1  last bit shifted out; 0 if no shift performed

Behaviour:
- Reset (rst high at a clock edge): state <= IDLE; busy=0, done=0, result=0, flagZ=0, flagC=0; internal shift register and counter cleared.
- Reset mid-operation aborts the operation; nothing completes, no done pulse.
- FSM states: IDLE, SHIFT, DONE. Encoding is free.
- IDLE:
  - If start=1 at edge k: capture a into the work register, capture op, set count = min(b, N), clear the carry register.
  - op=11 forces count=0.
  - Next state is SHIFT if count > 0, otherwise DONE.
  - start=0: remain in IDLE.
- SHIFT (one bit per edge, count decrements by 1 each edge):
  - LSR: work = {0, work[N-1:1]}, carry = work[0].
  - LSL: work = {work[N-2:0], 0}, carry = work[N-1].
  - ASR: work = {work[N-1], work[N-1:1]}, carry = work[0].
  - On the edge where count goes 1 -> 0: next state DONE.
  - result/flags are NOT updated during SHIFT; they keep the previous completion's values.
- DONE (exactly one cycle):
  - done=1, busy=1.
  - result = work register, flagZ = (work == 0), flagC = carry register. These are registered on entry to DONE.
  - Next state IDLE unconditionally.
- Latency: with start accepted at edge k, done is high in the cycle following edge k+count (count=0 gives the cycle after edge k). Total busy cycles = count+1.
- start while busy=1 is ignored. Operands are not re-sampled, and no queueing.
- start held high continuously: a new operation is accepted on the first edge back in IDLE. Minimum spacing between starts is count+2 edges.
- Boundary cases:
  - b >= N: count saturates at N.
  - LSR/LSL with b >= N: result = 0, flagC = a[N-1] (LSR) or a[0] (LSL).
  - ASR with b >= N: result = all copies of a[N-1], flagC = a[N-1].
  - b = 0 or op = 11: result = a, flagC = 0, flagZ = (a == 0).
- result, flagZ and flagC persist after done until the next DONE or reset.

Test Plan:
1. N=4, LSR a=1011, b=2, start 1 cycle -> busy for 3 cycles; done in 3rd cycle after accept edge. result=0010, flagC=1, flagZ=0.
2. LSL a=0011, b=3 -> done after 3 shift edges + 1. result=1000, flagC=1, flagZ=0.
3. ASR a=1000, b=9 (capped to 4) -> result=1111, flagC=1, flagZ=0, done after 4 shift edges.
4. LSR a=0000, b=0 -> done in cycle after accept edge. result=0000, flagZ=1, flagC=0. Repeat with op=11, a=0110, b=5 -> result=0110, flagC=0, 1-cycle latency.
5. LSR a=0001, b=15 -> result=0000, flagZ=1, flagC=0. During SHIFT, pulse start with a=1111, b=1 -> ignored; outputs unchanged until done.
6. Start LSL a=0101, b=3, assert rst on 2nd SHIFT cycle -> next cycle busy=0, done=0, result=0, flagZ=0, flagC=0, no done pulse. Then LSR a=0100, b=1 -> result=0010, normal timing.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Handshake and data bundle for shift_sequencer: request side (start/op/a/b)
// and completion side (busy/done/result/flags).
interface shift_sequencer_if #(
  parameter int N = 4
);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         flagZ;
  logic         flagC;

  modport master (
    output start, op, a, b,
    input  busy, done, result, flagZ, flagC
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, flagZ, flagC
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: LSR/LSL/ASR one bit per clock with start/busy/done
// handshake, iteration count capped at N, zero and carry-out flags.
module shift_sequencer #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] NCNT = CW'(N);
  localparam logic [N-1:0]  NOPD = N'(N);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] OP_LSR = 2'b00;
  localparam logic [1:0] OP_LSL = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  logic [1:0]    state;
  logic [N-1:0]  work;
  logic [N-1:0]  work_nx;
  logic          carry;
  logic          carry_nx;
  logic [1:0]    opr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cap;
  logic [N-1:0]  res_q;
  logic          fz_q;
  logic          fc_q;

  assign bus.busy   = (state == SHIFT) || (state == DONE);
  assign bus.done   = (state == DONE);
  assign bus.result = res_q;
  assign bus.flagZ  = fz_q;
  assign bus.flagC  = fc_q;

  always_comb begin
    cap = '0;
    if (bus.op == OP_NOP) begin
      cap = '0;
    end else if (bus.b >= NOPD) begin
      cap = NCNT;
    end else begin
      cap = CW'(bus.b);
    end
  end

  always_comb begin
    work_nx  = work;
    carry_nx = carry;
    case (opr)
      OP_LSR: begin
        work_nx  = {1'b0, work[N-1:1]};
        carry_nx = work[0];
      end
      OP_LSL: begin
        work_nx  = {work[N-2:0], 1'b0};
        carry_nx = work[N-1];
      end
      OP_ASR: begin
        work_nx  = {work[N-1], work[N-1:1]};
        carry_nx = work[0];
      end
      default: begin
        work_nx  = work;
        carry_nx = carry;
      end
    endcase
  end

  // Result and flags are loaded on the edge that enters DONE, from the
  // same values the work/carry registers take on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      carry <= 1'b0;
      opr   <= '0;
      cnt   <= '0;
      res_q <= '0;
      fz_q  <= 1'b0;
      fc_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            work  <= bus.a;
            opr   <= bus.op;
            carry <= 1'b0;
            cnt   <= cap;
            if (cap == '0) begin
              state <= DONE;
              res_q <= bus.a;
              fz_q  <= (bus.a == '0);
              fc_q  <= 1'b0;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work  <= work_nx;
          carry <= carry_nx;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            res_q <= work_nx;
            fz_q  <= (work_nx == '0);
            fc_q  <= carry_nx;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (N=4).
module tb_shift_sequencer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  shift_sequencer_if #(.N(4)) bus();

  shift_sequencer #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_op(input logic [1:0] o, input logic [3:0] av, input logic [3:0] bv,
                        input int exp_lat, input logic [3:0] exp_r, input logic exp_c,
                        input logic exp_z, input string name);
    int lat;
    bit bad_busy;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    bad_busy = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.busy !== 1'b1) bad_busy = 1;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (bad_busy !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL %s busy: got busy=%b gap=%0b expected busy=1 gap=0", name, bus.busy, bad_busy);
    end
    checks++;
    if (bus.result !== exp_r) begin
      errors++; $display("FAIL %s result: got %b expected %b", name, bus.result, exp_r);
    end
    checks++;
    if (bus.flagC !== exp_c || bus.flagZ !== exp_z) begin
      errors++; $display("FAIL %s flags: got C=%b Z=%b expected C=%b Z=%b", name, bus.flagC, bus.flagZ, exp_c, exp_z);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== exp_r) begin
      errors++; $display("FAIL %s after_done: got done=%b busy=%b result=%b expected 0 0 %b",
                         name, bus.done, bus.busy, bus.result, exp_r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 4'h0; bus.b = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 4'h0 ||
        bus.flagZ !== 1'b0 || bus.flagC !== 1'b0) begin
      errors++; $display("FAIL reset_state: got busy=%b done=%b result=%b Z=%b C=%b expected all 0",
                         bus.busy, bus.done, bus.result, bus.flagZ, bus.flagC);
    end
  endtask

  task automatic test_shifts();
    run_op(2'b00, 4'b1011, 4'd2, 2, 4'b0010, 1'b1, 1'b0, "lsr_1011_b2");
    run_op(2'b01, 4'b0011, 4'd3, 3, 4'b1000, 1'b1, 1'b0, "lsl_0011_b3");
    run_op(2'b10, 4'b1000, 4'd9, 4, 4'b1111, 1'b1, 1'b0, "asr_1000_b9");
    run_op(2'b10, 4'b0110, 4'd1, 1, 4'b0011, 1'b0, 1'b0, "asr_0110_b1");
    run_op(2'b01, 4'b1001, 4'd4, 4, 4'b0000, 1'b1, 1'b1, "lsl_1001_b4");
  endtask

  task automatic test_zero_count();
    run_op(2'b00, 4'b0000, 4'd0, 0, 4'b0000, 1'b0, 1'b1, "lsr_b0_zero");
    run_op(2'b11, 4'b0110, 4'd5, 0, 4'b0110, 1'b0, 1'b0, "op11_pass");
  endtask

  task automatic test_busy_ignore();
    int lat;
    bit held_bad;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 4'b0001; bus.b = 4'd15;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.result !== 4'b0110 || bus.done !== 1'b0) begin
      errors++; $display("FAIL ignore_hold_early: got result=%b done=%b expected 0110 0", bus.result, bus.done);
    end
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 4'b1111; bus.b = 4'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    held_bad = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.result !== 4'b0110) held_bad = 1;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4 || held_bad !== 1'b0) begin
      errors++; $display("FAIL ignore_latency: got lat=%0d held_bad=%0b expected 4 0", lat, held_bad);
    end
    checks++;
    if (bus.result !== 4'b0000 || bus.flagZ !== 1'b1 || bus.flagC !== 1'b0) begin
      errors++; $display("FAIL ignore_result: got %b Z=%b C=%b expected 0000 Z=1 C=0",
                         bus.result, bus.flagZ, bus.flagC);
    end
    held_bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) held_bad = 1;
    end
    checks++;
    if (held_bad !== 1'b0 || bus.result !== 4'b0000) begin
      errors++; $display("FAIL ignore_no_queue: got extra activity=%0b result=%b expected 0 0000",
                         held_bad, bus.result);
    end
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    run_op(2'b01, 4'b1110, 4'd0, 0, 4'b1110, 1'b0, 1'b0, "preload");
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 4'b0101; bus.b = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 4'h0 ||
        bus.flagZ !== 1'b0 || bus.flagC !== 1'b0) begin
      errors++; $display("FAIL abort_state: got busy=%b done=%b result=%b Z=%b C=%b expected all 0",
                         bus.busy, bus.done, bus.result, bus.flagZ, bus.flagC);
    end
    saw_done = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: got activity=1 expected 0");
    end
    run_op(2'b00, 4'b0100, 4'd1, 1, 4'b0010, 1'b0, 1'b0, "post_reset_lsr");
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 4'b1000; bus.b = 4'd1;
    @(posedge clk); #1;
    bus.op = 2'b01; bus.a = 4'b0110; bus.b = 4'd0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL b2b_first_shift: got busy=%b done=%b expected 1 0", bus.busy, bus.done);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b1 || bus.result !== 4'b0100 || bus.flagC !== 1'b0) begin
      errors++; $display("FAIL b2b_first_done: got done=%b result=%b C=%b expected 1 0100 0",
                         bus.done, bus.result, bus.flagC);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.result !== 4'b0110 || bus.flagC !== 1'b0 || bus.flagZ !== 1'b0) begin
      errors++; $display("FAIL b2b_second_done: got done=%b result=%b C=%b Z=%b expected 1 0110 0 0",
                         bus.done, bus.result, bus.flagC, bus.flagZ);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.result !== 4'b0110) begin
      errors++; $display("FAIL b2b_end: got busy=%b result=%b expected 0 0110", bus.busy, bus.result);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_shifts();
    test_zero_count();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
